// File: rtl/round_scorer.sv
// round_scorer: runs one timed round and counts sequence matches for two
// players. Stop rises when the round timer expires or either count reaches 15.
// Optional feature macro ROUND_SCORER_MATCH_EDGE_EN: when defined, MatchA and
// MatchB count only on 0->1 transitions instead of once per high cycle.
module round_scorer #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned ROUND_SECS = 30
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       MatchA,
  input  logic       MatchB,
  output logic [3:0] CounterA_out,
  output logic [3:0] CounterB_out,
  output logic       Stop,
  output logic       StopByCount,
  output logic [7:0] TimeLeft,
  output logic       Busy
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [7:0]    ROUND_INIT = 8'(ROUND_SECS);
  localparam logic [3:0]    CNT_MAX    = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          hit_a;
  logic          hit_b;
  logic [3:0]    next_a;
  logic [3:0]    next_b;
  logic          tick;
  logic          sat;
  logic          last_tick;

`ifdef ROUND_SCORER_MATCH_EDGE_EN
  logic match_a_q;
  logic match_b_q;

  // Previous match levels; always tracking so a level held across Start never counts.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      match_a_q <= 1'b0;
      match_b_q <= 1'b0;
    end else begin
      match_a_q <= MatchA;
      match_b_q <= MatchB;
    end
  end

  // A match is a rising edge of the checker output.
  always_comb begin
    hit_a = MatchA & ~match_a_q;
    hit_b = MatchB & ~match_b_q;
  end
`else
  // A match is every cycle the checker output is high.
  always_comb begin
    hit_a = MatchA;
    hit_b = MatchB;
  end
`endif

  // Saturating next counts plus the two round-ending conditions.
  always_comb begin
    next_a    = CounterA_out;
    next_b    = CounterB_out;
    if (hit_a && (CounterA_out != CNT_MAX)) next_a = CounterA_out + 4'd1;
    if (hit_b && (CounterB_out != CNT_MAX)) next_b = CounterB_out + 4'd1;
    sat       = (next_a == CNT_MAX) || (next_b == CNT_MAX);
    tick      = (prescaler == PRE_LAST);
    last_tick = tick && (TimeLeft == 8'd1);
  end

  // Round FSM with registered outputs; count saturation wins over timer expiry.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state        <= IDLE;
      prescaler    <= '0;
      CounterA_out <= 4'd0;
      CounterB_out <= 4'd0;
      Stop         <= 1'b0;
      StopByCount  <= 1'b0;
      TimeLeft     <= 8'd0;
      Busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state        <= RUN;
            prescaler    <= '0;
            CounterA_out <= 4'd0;
            CounterB_out <= 4'd0;
            Stop         <= 1'b0;
            StopByCount  <= 1'b0;
            TimeLeft     <= ROUND_INIT;
            Busy         <= 1'b1;
          end
        end
        RUN: begin
          CounterA_out <= next_a;
          CounterB_out <= next_b;
          if (tick) begin
            prescaler <= '0;
            TimeLeft  <= TimeLeft - 8'd1;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
          if (sat) begin
            state       <= DONE;
            Stop        <= 1'b1;
            StopByCount <= 1'b1;
            Busy        <= 1'b0;
          end else if (last_tick) begin
            state       <= DONE;
            Stop        <= 1'b1;
            StopByCount <= 1'b0;
            Busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_scorer.sv
// Bench for round_scorer: two instances (short tick, long tick); round results
// are queued at Start and compared when Stop rises.
module tb_round_scorer;

  logic       Clk;
  logic       Rst;
  logic       s1, ma1, mb1, s2, ma2, mb2;
  logic [3:0] ca1, cb1, ca2, cb2;
  logic       stop1, sbc1, busy1, stop2, sbc2, busy2;
  logic [7:0] tl1, tl2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic        stop1_q = 1'b0;
  logic        stop2_q = 1'b0;

  round_scorer #(.TICK_DIV(4), .ROUND_SECS(3)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(s1), .MatchA(ma1), .MatchB(mb1),
    .CounterA_out(ca1), .CounterB_out(cb1), .Stop(stop1),
    .StopByCount(sbc1), .TimeLeft(tl1), .Busy(busy1)
  );

  round_scorer #(.TICK_DIV(100), .ROUND_SECS(3)) dut2 (
    .Clk(Clk), .Rst(Rst), .Start(s2), .MatchA(ma2), .MatchB(mb2),
    .CounterA_out(ca2), .CounterB_out(cb2), .Stop(stop2),
    .StopByCount(sbc2), .TimeLeft(tl2), .Busy(busy2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [16:0] res(input int a, input int b, input int sbc, input int tl);
    return {4'(a), 4'(b), 1'(sbc), 8'(tl)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: on each Stop rise compare {A, B, StopByCount, TimeLeft} with the queue head.
  always @(negedge Clk) begin
    if (stop1 && !stop1_q) begin
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL dut1_unexpected_stop: got result %0h expected none", {ca1, cb1, sbc1, tl1});
      end else begin
        check("dut1_result", 32'({ca1, cb1, sbc1, tl1}), 32'(q1.pop_front()));
      end
    end
    if (stop2 && !stop2_q) begin
      if (q2.size() == 0) begin
        total_cnt++;
        $display("FAIL dut2_unexpected_stop: got result %0h expected none", {ca2, cb2, sbc2, tl2});
      end else begin
        check("dut2_result", 32'({ca2, cb2, sbc2, tl2}), 32'(q2.pop_front()));
      end
    end
    stop1_q = stop1;
    stop2_q = stop2;
  end

  initial begin
    logic [12:1] a_pat;
    logic [12:1] b_pat;
    Rst = 1'b0;
    s1 = 0; ma1 = 0; mb1 = 0; s2 = 0; ma2 = 0; mb2 = 0;
    repeat (2) @(negedge Clk);
    check("rst_state_dut1", 32'({ca1, cb1, stop1, sbc1, tl1, busy1}), 32'd0);
    check("rst_state_dut2", 32'({ca2, cb2, stop2, sbc2, tl2, busy2}), 32'd0);
    Rst = 1'b1;

    // Round with no matches: timer end on the 12th RUN edge.
    @(negedge Clk); s1 = 1; q1.push_back(res(0, 0, 0, 0));
    @(negedge Clk); s1 = 0;
    check("t1_busy_after_start", 32'(busy1), 32'd1);
    check("t1_tl_start", 32'(tl1), 32'd3);
    repeat (3) @(negedge Clk);
    check("t1_tl_e3", 32'(tl1), 32'd3);
    @(negedge Clk);
    check("t1_tl_e4", 32'(tl1), 32'd2);
    repeat (4) @(negedge Clk);
    check("t1_tl_e8", 32'(tl1), 32'd1);
    repeat (3) @(negedge Clk);
    check("t1_stop_e11", 32'({stop1, busy1}), 32'b01);
    @(negedge Clk);
    check("t1_busy_e12", 32'(busy1), 32'd0);

    // Restart from DONE: 2 A pulses, 5 B pulses (one coincident with an A pulse).
    @(negedge Clk); s1 = 1; q1.push_back(res(2, 5, 0, 0));
    @(negedge Clk); s1 = 0;
    check("t2_stop_drops", 32'({stop1, ca1, busy1}), 32'h1);
    a_pat = '0; b_pat = '0;
    a_pat[1] = 1; a_pat[3] = 1;
    b_pat[1] = 1; b_pat[5] = 1; b_pat[7] = 1; b_pat[9] = 1; b_pat[11] = 1;
    for (int k = 1; k <= 12; k++) begin
      ma1 = a_pat[k]; mb1 = b_pat[k];
      @(negedge Clk);
    end
    ma1 = 0; mb1 = 0;
    check("t2_done_ignores", 32'({ca1, cb1}), 32'h25);

    // Reset mid-round with counts 3/4, then a clean round.
    @(negedge Clk); s1 = 1;
    @(negedge Clk); s1 = 0;
    a_pat = '0; b_pat = '0;
    a_pat[1] = 1; a_pat[3] = 1; a_pat[5] = 1;
    b_pat[2] = 1; b_pat[4] = 1; b_pat[6] = 1; b_pat[8] = 1;
    for (int k = 1; k <= 8; k++) begin
      ma1 = a_pat[k]; mb1 = b_pat[k];
      @(negedge Clk);
    end
    ma1 = 0; mb1 = 0;
    check("t3_mid_counts", 32'({ca1, cb1, tl1}), 32'h3401);
    #2 Rst = 1'b0;
    #1 check("t3_async_reset", 32'({ca1, cb1, stop1, sbc1, tl1, busy1}), 32'd0);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk); s1 = 1; q1.push_back(res(0, 0, 0, 0));
    @(negedge Clk); s1 = 0;
    check("t3_clean_start", 32'({ca1, cb1, tl1, busy1}), 32'({16'h0003, 1'b1}));
    repeat (12) @(negedge Clk);

`ifndef ROUND_SCORER_MATCH_EDGE_EN
    // Held MatchA saturates at 15 on the 15th RUN edge; DONE ignores more pulses.
    @(negedge Clk); s2 = 1; q2.push_back(res(15, 0, 1, 3));
    @(negedge Clk); s2 = 0; ma2 = 1;
    repeat (15) @(negedge Clk);
    ma2 = 0;
    check("t4_sat_a", 32'(ca2), 32'd15);
    for (int i = 0; i < 3; i++) begin
      ma2 = 1; @(negedge Clk); ma2 = 0; @(negedge Clk);
    end
    check("t4_hold_done", 32'({ca2, stop2, sbc2, busy2}), 32'({4'hF, 3'b110}));
`else
    // Held level counts once; separate pulses count each.
    @(negedge Clk); s2 = 1; q2.push_back(res(4, 0, 0, 0));
    @(negedge Clk); s2 = 0; ma2 = 1;
    repeat (10) @(negedge Clk);
    ma2 = 0; @(negedge Clk);
    check("t6_held_once", 32'(ca2), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ma2 = 1; @(negedge Clk); ma2 = 0; @(negedge Clk);
    end
    check("t6_pulses", 32'(ca2), 32'd4);
    repeat (290) @(negedge Clk);
`endif

    // Count reaches 15 on the same edge as the final timer tick: count wins.
    @(negedge Clk); s2 = 1; q2.push_back(res(15, 0, 1, 0));
    @(negedge Clk); s2 = 0;
    for (int i = 0; i < 14; i++) begin
      ma2 = 1; @(negedge Clk); ma2 = 0; @(negedge Clk);
    end
    check("t5_count14", 32'({ca2, tl2}), 32'h0E03);
    repeat (271) @(negedge Clk);
    check("t5_before_final", 32'({ca2, tl2, stop2}), 32'({12'hE01, 1'b0}));
    ma2 = 1; @(negedge Clk); ma2 = 0;
    check("t5_final_busy", 32'(busy2), 32'd0);

    repeat (3) @(negedge Clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
